// File: rtl/mii_frame_monitor_pkg.sv
// Shared definitions for the MII frame monitor: control codes, FSM state
// encoding and the per-word lane scan result.
package mii_pkg;

  localparam logic [7:0] CODE_IDLE  = 8'h07;
  localparam logic [7:0] CODE_START = 8'hFB;
  localparam logic [7:0] CODE_TERM  = 8'hFD;

  // Lane indices are carried at a fixed width so the struct is
  // independent of the lane count (up to 256 lanes).
  localparam int SCAN_LANE_W = 8;

  typedef enum logic [1:0] {
    WAIT_START = 2'd0,
    IN_FRAME   = 2'd1,
    IN_GAP     = 2'd2
  } state_t;

  // Result of scanning one bus word, lowest lane has priority.
  //   term_found/term_lane    : first lane carrying ctrl=1 TERM
  //   start_found/start_lane  : first lane carrying ctrl=1 START
  //   illegal                 : some ctrl=1 byte is not IDLE/START/TERM
  //   data_in_gap             : a ctrl=0 byte sits in a lane that belongs to
  //                             the gap (after TERM and/or before START)
  //   multi_code              : more than one TERM, more than one START, or a
  //                             START that precedes the TERM in the word
  //   ctrl_before_term        : some ctrl=1 byte lies below the first TERM
  //                             (anywhere in the word when there is no TERM)
  typedef struct packed {
    logic                   term_found;
    logic [SCAN_LANE_W-1:0] term_lane;
    logic                   start_found;
    logic [SCAN_LANE_W-1:0] start_lane;
    logic                   illegal;
    logic                   data_in_gap;
    logic                   multi_code;
    logic                   ctrl_before_term;
  } scan_t;

endpackage

// File: rtl/mii_frame_monitor_if.sv
// Bus bundle between the TX path (master) and the passive frame monitor
// (slave). Words are qualified by i_valid alone: a word is consumed on every
// clock edge where i_valid=1 and there is no ready, because the monitor can
// never stall the TX path. Results come back as registered pulses/counters.
interface mii_frame_monitor_if #(
  parameter int LANES     = 8,
  parameter int LEN_WIDTH = 16,
  parameter int CNT_WIDTH = 16
) ();

  logic                 i_valid;
  logic [8*LANES-1:0]   i_tx_data;
  logic [LANES-1:0]     i_tx_ctrl;
  logic                 i_clr_stats;

  logic                 o_frame_valid;
  logic [LEN_WIDTH-1:0] o_frame_len;
  logic                 o_payload_err;
  logic                 o_ipg_err;
  logic                 o_ctrl_err;
  logic [CNT_WIDTH-1:0] o_frame_cnt;
  logic [CNT_WIDTH-1:0] o_err_cnt;
  mii_pkg::state_t      o_dbg_state;

  modport master (
    output i_valid, i_tx_data, i_tx_ctrl, i_clr_stats,
    input  o_frame_valid, o_frame_len, o_payload_err, o_ipg_err,
           o_ctrl_err, o_frame_cnt, o_err_cnt, o_dbg_state
  );

  modport slave (
    input  i_valid, i_tx_data, i_tx_ctrl, i_clr_stats,
    output o_frame_valid, o_frame_len, o_payload_err, o_ipg_err,
           o_ctrl_err, o_frame_cnt, o_err_cnt, o_dbg_state
  );

endinterface

// File: rtl/mii_frame_monitor_lane_scan.sv
// Combinational scan of one bus word: locates the first TERM and START
// codes and classifies every other byte relative to them.
module mii_lane_scan
  import mii_pkg::*;
#(
  parameter int LANES = 8
) (
  input  logic [8*LANES-1:0] data_i,
  input  logic [LANES-1:0]   ctrl_i,
  output scan_t              scan_o
);

  // Two passes: first locate the codes, then classify lanes against them.
  always_comb begin
    scan_t                  res;
    logic [7:0]             byte_v;
    logic [SCAN_LANE_W-1:0] lane_v;
    logic                   pair_v;
    logic                   gap_lane_v;

    res        = '0;
    byte_v     = '0;
    lane_v     = '0;
    pair_v     = 1'b0;
    gap_lane_v = 1'b0;

    for (int k = 0; k < LANES; k++) begin
      byte_v = data_i[8*k +: 8];
      lane_v = SCAN_LANE_W'(k);
      if (ctrl_i[k]) begin
        if (byte_v == CODE_TERM) begin
          if (res.term_found) begin
            res.multi_code = 1'b1;
          end else begin
            res.term_found = 1'b1;
            res.term_lane  = lane_v;
          end
        end else if (byte_v == CODE_START) begin
          if (res.start_found) begin
            res.multi_code = 1'b1;
          end else begin
            res.start_found = 1'b1;
            res.start_lane  = lane_v;
          end
        end else if (byte_v != CODE_IDLE) begin
          res.illegal = 1'b1;
        end
      end
    end

    // A START only pairs with the TERM when it follows it.
    pair_v = res.term_found && res.start_found && (res.start_lane > res.term_lane);
    if (res.term_found && res.start_found && !pair_v) begin
      res.multi_code = 1'b1;
    end

    for (int k = 0; k < LANES; k++) begin
      lane_v = SCAN_LANE_W'(k);
      if (res.term_found) begin
        gap_lane_v = (lane_v > res.term_lane) && (!pair_v || (lane_v < res.start_lane));
      end else begin
        gap_lane_v = !res.start_found || (lane_v < res.start_lane);
      end
      if (!ctrl_i[k] && gap_lane_v) begin
        res.data_in_gap = 1'b1;
      end
      if (ctrl_i[k] && (!res.term_found || (lane_v < res.term_lane))) begin
        res.ctrl_before_term = 1'b1;
      end
    end

    scan_o = res;
  end

endmodule

// File: rtl/mii_frame_monitor.sv
// Passive monitor for an N-lane xGMII-style TX bus: checks payload length,
// inter-packet gap and control-code legality, and keeps saturating frame and
// error statistics. All outputs are registered one cycle after the word.
module mii_frame_monitor
  import mii_pkg::*;
#(
  parameter int LANES       = 8,
  parameter int MIN_PAYLOAD = 46,
  parameter int MAX_PAYLOAD = 150,
  parameter int MIN_IPG     = 12,
  parameter int MAX_IPG     = 40,
  parameter int LEN_WIDTH   = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                clk,
  input  logic                i_rst_n,
  mii_frame_monitor_if.slave  mon
);

  localparam logic [1:0] ST_WAIT_START = 2'd0;
  localparam logic [1:0] ST_IN_FRAME   = 2'd1;
  localparam logic [1:0] ST_IN_GAP     = 2'd2;

  localparam logic [LEN_WIDTH-1:0] LANES_LEN   = LEN_WIDTH'(LANES);
  localparam logic [LEN_WIDTH-1:0] LAST_LANE   = LEN_WIDTH'(LANES - 1);
  localparam logic [LEN_WIDTH-1:0] MIN_PAY_LEN = LEN_WIDTH'(MIN_PAYLOAD);
  localparam logic [LEN_WIDTH-1:0] MAX_PAY_LEN = LEN_WIDTH'(MAX_PAYLOAD);
  localparam logic [LEN_WIDTH-1:0] MIN_IPG_LEN = LEN_WIDTH'(MIN_IPG);
  localparam logic [LEN_WIDTH-1:0] MAX_IPG_LEN = LEN_WIDTH'(MAX_IPG);

  function automatic logic [LEN_WIDTH-1:0] sat_add(
    input logic [LEN_WIDTH-1:0] a,
    input logic [LEN_WIDTH-1:0] b
  );
    logic [LEN_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[LEN_WIDTH] ? '1 : sum[LEN_WIDTH-1:0];
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  scan_t scan;

  logic [1:0]           state_q,       state_d;
  logic [LEN_WIDTH-1:0] len_q,         len_d;
  logic [LEN_WIDTH-1:0] gap_q,         gap_d;
  logic                 frame_valid_q, frame_valid_d;
  logic [LEN_WIDTH-1:0] frame_len_q,   frame_len_d;
  logic                 payload_err_q, payload_err_d;
  logic                 ipg_err_q,     ipg_err_d;
  logic                 ctrl_err_q,    ctrl_err_d;
  logic [CNT_WIDTH-1:0] frame_cnt_q,   frame_cnt_d;
  logic [CNT_WIDTH-1:0] err_cnt_q,     err_cnt_d;

  mii_lane_scan #(
    .LANES (LANES)
  ) u_scan (
    .data_i (mon.i_tx_data),
    .ctrl_i (mon.i_tx_ctrl),
    .scan_o (scan)
  );

  // Frame/gap tracking FSM and per-word error pulses.
  always_comb begin
    logic [LEN_WIDTH-1:0] s_len;
    logic [LEN_WIDTH-1:0] t_len;
    logic [LEN_WIDTH-1:0] gap_sum;
    logic [LEN_WIDTH-1:0] flen;
    logic                 pair;

    state_d       = state_q;
    len_d         = len_q;
    gap_d         = gap_q;
    frame_len_d   = frame_len_q;
    frame_valid_d = 1'b0;
    payload_err_d = 1'b0;
    ipg_err_d     = 1'b0;
    ctrl_err_d    = 1'b0;

    s_len   = LEN_WIDTH'(scan.start_lane);
    t_len   = LEN_WIDTH'(scan.term_lane);
    pair    = scan.term_found && scan.start_found && (scan.start_lane > scan.term_lane);
    gap_sum = '0;
    flen    = '0;

    if (mon.i_valid) begin
      ctrl_err_d = scan.illegal | scan.multi_code;
      case (state_q)
        ST_WAIT_START: begin
          // No gap reference exists yet, so the first START is not IPG-checked.
          if (scan.term_found) ctrl_err_d = 1'b1;
          if (scan.start_found) begin
            state_d = ST_IN_FRAME;
            len_d   = LAST_LANE - s_len;
          end
        end

        ST_IN_GAP: begin
          if (scan.term_found || scan.data_in_gap) ctrl_err_d = 1'b1;
          if (scan.start_found) begin
            gap_sum   = sat_add(gap_q, s_len);
            ipg_err_d = (gap_sum < MIN_IPG_LEN) || (gap_sum > MAX_IPG_LEN);
            state_d   = ST_IN_FRAME;
            len_d     = LAST_LANE - s_len;
          end else begin
            gap_d = sat_add(gap_q, LANES_LEN);
          end
        end

        ST_IN_FRAME: begin
          if (scan.term_found) begin
            // The frame is reported even when the tail of the word is bad.
            flen          = sat_add(len_q, t_len);
            frame_valid_d = 1'b1;
            frame_len_d   = flen;
            payload_err_d = (flen < MIN_PAY_LEN) || (flen > MAX_PAY_LEN);
            if (scan.ctrl_before_term || scan.data_in_gap) ctrl_err_d = 1'b1;
            if (pair) begin
              gap_sum   = s_len - t_len - 1'b1;
              ipg_err_d = (gap_sum < MIN_IPG_LEN) || (gap_sum > MAX_IPG_LEN);
              len_d     = LAST_LANE - s_len;
            end else begin
              gap_d   = LAST_LANE - t_len;
              state_d = ST_IN_GAP;
            end
          end else begin
            if (scan.ctrl_before_term) ctrl_err_d = 1'b1;
            if (scan.illegal) begin
              // Abort: the frame is dropped and gap counting restarts.
              gap_d   = '0;
              state_d = ST_IN_GAP;
            end else if (scan.start_found) begin
              len_d = LAST_LANE - s_len;
            end else begin
              len_d = sat_add(len_q, LANES_LEN);
            end
          end
        end

        default: state_d = ST_WAIT_START;
      endcase
    end
  end

  // Saturating statistics; a clear wins over an increment in the same cycle.
  always_comb begin
    logic any_err;
    any_err     = payload_err_d | ipg_err_d | ctrl_err_d;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (mon.i_clr_stats) begin
      frame_cnt_d = '0;
      err_cnt_d   = '0;
    end else begin
      if (frame_valid_d && !any_err) frame_cnt_d = sat_inc(frame_cnt_q);
      if (any_err) err_cnt_d = sat_inc(err_cnt_q);
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_WAIT_START;
      len_q         <= '0;
      gap_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_len_q   <= '0;
      payload_err_q <= 1'b0;
      ipg_err_q     <= 1'b0;
      ctrl_err_q    <= 1'b0;
      frame_cnt_q   <= '0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      gap_q         <= gap_d;
      frame_valid_q <= frame_valid_d;
      frame_len_q   <= frame_len_d;
      payload_err_q <= payload_err_d;
      ipg_err_q     <= ipg_err_d;
      ctrl_err_q    <= ctrl_err_d;
      frame_cnt_q   <= frame_cnt_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign mon.o_frame_valid = frame_valid_q;
  assign mon.o_frame_len   = frame_len_q;
  assign mon.o_payload_err = payload_err_q;
  assign mon.o_ipg_err     = ipg_err_q;
  assign mon.o_ctrl_err    = ctrl_err_q;
  assign mon.o_frame_cnt   = frame_cnt_q;
  assign mon.o_err_cnt     = err_cnt_q;
  assign mon.o_dbg_state   = state_t'(state_q);

endmodule

// File: tb/tb_mii_frame_monitor.sv
// Directed bench for mii_frame_monitor with LANES=8.
module tb_mii_frame_monitor;

  localparam int LANES = 8;
  localparam logic [7:0] IDLE  = 8'h07;
  localparam logic [7:0] START = 8'hFB;
  localparam logic [7:0] TERM  = 8'hFD;

  logic clk;
  logic i_rst_n;
  int   checks;
  int   failures;

  logic [63:0] wd;
  logic [7:0]  wc;

  mii_frame_monitor_if #(.LANES(LANES), .LEN_WIDTH(16), .CNT_WIDTH(16)) mon ();

  mii_frame_monitor #(
    .LANES(LANES), .MIN_PAYLOAD(46), .MAX_PAYLOAD(150),
    .MIN_IPG(12), .MAX_IPG(40), .LEN_WIDTH(16), .CNT_WIDTH(16)
  ) dut (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .mon     (mon)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_p(input string tag, input logic fv, input logic pe,
                       input logic ie, input logic ce);
    chk({tag, ".frame_valid"}, 32'(mon.o_frame_valid), 32'(fv));
    chk({tag, ".payload_err"}, 32'(mon.o_payload_err), 32'(pe));
    chk({tag, ".ipg_err"},     32'(mon.o_ipg_err),     32'(ie));
    chk({tag, ".ctrl_err"},    32'(mon.o_ctrl_err),    32'(ce));
  endtask

  task automatic chk_c(input string tag, input int fc, input int ec);
    chk({tag, ".frame_cnt"}, 32'(mon.o_frame_cnt), 32'(fc));
    chk({tag, ".err_cnt"},   32'(mon.o_err_cnt),   32'(ec));
  endtask

  task automatic fill_data();
    for (int k = 0; k < LANES; k++) wd[8*k +: 8] = 8'(8'h40 + k);
    wc = '0;
  endtask

  task automatic fill_idle();
    for (int k = 0; k < LANES; k++) wd[8*k +: 8] = IDLE;
    wc = '1;
  endtask

  task automatic put(input int k, input logic [7:0] code);
    wd[8*k +: 8] = code;
    wc[k] = 1'b1;
  endtask

  task automatic idle_from(input int k);
    for (int j = k; j < LANES; j++) put(j, IDLE);
  endtask

  // Present the current word for one clock; outputs are valid on return.
  task automatic send();
    @(negedge clk);
    mon.i_valid   = 1'b1;
    mon.i_tx_data = wd;
    mon.i_tx_ctrl = wc;
    @(posedge clk);
    #1;
    mon.i_valid = 1'b0;
  endtask

  task automatic send_data_words(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      fill_data();
      send();
      chk_p(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    i_rst_n = 1'b0;
    mon.i_valid = 1'b0;
    mon.i_tx_data = '0;
    mon.i_tx_ctrl = '0;
    mon.i_clr_stats = 1'b0;
    wd = '0;
    wc = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_p("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_c("reset", 0, 0);
    chk("reset.len", 32'(mon.o_frame_len), 32'd0);
    chk("reset.state", 32'(mon.o_dbg_state), 32'd0);
    @(negedge clk);
    i_rst_n = 1'b1;

    // Good frame: 7 + 5*8 + 3 = 50
    fill_data(); put(0, START); send();
    chk_p("good.start", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("good.state", 32'(mon.o_dbg_state), 32'd1);
    send_data_words("good.data", 5);
    fill_data(); put(3, TERM); idle_from(4); send();
    chk_p("good.term", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("good.len", 32'(mon.o_frame_len), 32'd50);
    chk_c("good", 1, 0);
    chk("good.state_gap", 32'(mon.o_dbg_state), 32'd2);

    // IPG exactly 12 (4 + 8 + 0), then a runt of 7 + 2 = 9
    fill_idle(); send();
    chk_p("ipg12.idle", 1'b0, 1'b0, 1'b0, 1'b0);
    fill_data(); put(0, START); send();
    chk_p("ipg12.start", 1'b0, 1'b0, 1'b0, 1'b0);
    fill_data(); put(2, TERM); idle_from(3); send();
    chk_p("runt.term", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("runt.len", 32'(mon.o_frame_len), 32'd9);
    chk_c("runt", 1, 1);

    // Gap 5 + 8 = 13, frame of 7 + 40 + 7 = 54 ending in lane 7
    fill_idle(); send();
    fill_data(); put(0, START); send();
    chk_p("f54.start", 1'b0, 1'b0, 1'b0, 1'b0);
    send_data_words("f54.data", 5);
    fill_data(); put(7, TERM); send();
    chk_p("f54.term", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("f54.len", 32'(mon.o_frame_len), 32'd54);
    chk_c("f54", 2, 1);

    // Zero gap: START lane 0 straight after TERM lane 7
    fill_data(); put(0, START); send();
    chk_p("ipg0.start", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ipg0.len_hold", 32'(mon.o_frame_len), 32'd54);
    chk_c("ipg0", 2, 2);

    // Same-word TERM lane1 / START lane5: frame 47 + 1 = 48, gap 3
    send_data_words("pair.data", 5);
    fill_data(); put(1, TERM); put(2, IDLE); put(3, IDLE); put(4, IDLE); put(5, START);
    send();
    chk_p("pair.word", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("pair.len", 32'(mon.o_frame_len), 32'd48);
    chk_c("pair", 2, 3);
    chk("pair.state", 32'(mon.o_dbg_state), 32'd1);

    // Next frame starts at 2: 2 + 40 + 4 = 46 (minimum legal)
    send_data_words("after_pair.data", 5);
    fill_data(); put(4, TERM); idle_from(5); send();
    chk_p("min46.term", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("min46.len", 32'(mon.o_frame_len), 32'd46);
    chk_c("min46", 3, 3);

    // Stray TERM in the gap (gap 3 -> 11, still counting)
    fill_idle(); put(2, TERM); send();
    chk_p("gap_term", 1'b0, 1'b0, 1'b0, 1'b1);
    chk_c("gap_term", 3, 4);
    chk("gap_term.state", 32'(mon.o_dbg_state), 32'd2);
    fill_idle(); send();

    // Illegal control byte mid-frame aborts the frame (gap 19 before it)
    fill_data(); put(0, START); send();
    chk_p("illegal.start", 1'b0, 1'b0, 1'b0, 1'b0);
    send_data_words("illegal.data", 1);
    fill_data(); put(4, 8'hFE); send();
    chk_p("illegal.word", 1'b0, 1'b0, 1'b0, 1'b1);
    chk_c("illegal", 3, 5);
    chk("illegal.state", 32'(mon.o_dbg_state), 32'd2);

    // Gap 0 + 16 after the abort, then a normal 50-byte frame
    fill_idle(); send();
    fill_idle(); send();
    fill_data(); put(0, START); send();
    chk_p("recover.start", 1'b0, 1'b0, 1'b0, 1'b0);
    send_data_words("recover.data", 5);
    fill_data(); put(3, TERM); idle_from(4); send();
    chk_p("recover.term", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("recover.len", 32'(mon.o_frame_len), 32'd50);
    chk_c("recover", 4, 5);

    // A word with i_valid low is ignored, even if it carries TERM
    @(negedge clk);
    mon.i_tx_data = {8{TERM}};
    mon.i_tx_ctrl = '1;
    mon.i_valid   = 1'b0;
    @(posedge clk);
    #1;
    chk_p("novalid", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_c("novalid", 4, 5);
    chk("novalid.state", 32'(mon.o_dbg_state), 32'd2);

    // Synchronous statistics clear
    @(negedge clk);
    mon.i_clr_stats = 1'b1;
    @(posedge clk);
    #1;
    mon.i_clr_stats = 1'b0;
    chk_c("clr", 0, 0);

    // Oversize frame: gap 4 + 8 = 12, then 7 + 18*8 + 0 = 151
    fill_idle(); send();
    fill_data(); put(0, START); send();
    chk_p("big.start", 1'b0, 1'b0, 1'b0, 1'b0);
    send_data_words("big.data", 18);
    fill_data(); put(0, TERM); idle_from(1); send();
    chk_p("big.term", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("big.len", 32'(mon.o_frame_len), 32'd151);
    chk_c("big", 0, 1);

    // Asynchronous reset mid-frame
    fill_idle(); send();
    fill_data(); put(0, START); send();
    send_data_words("rst.data", 1);
    #3;
    i_rst_n = 1'b0;
    #1;
    chk_p("rst.during", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_c("rst.during", 0, 0);
    chk("rst.len", 32'(mon.o_frame_len), 32'd0);
    chk("rst.state", 32'(mon.o_dbg_state), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;
    fill_data(); put(3, TERM); idle_from(4); send();
    chk_p("rst.term", 1'b0, 1'b0, 1'b0, 1'b1);
    chk_c("rst.term", 0, 1);
    chk("rst.term_state", 32'(mon.o_dbg_state), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mii_frame_monitor.md
Name: mii_frame_monitor

Overview:
- Parametrised successor of the single-word 64-bit MII checker.
- Passive monitor on an N-lane xGMII-style TX bus (8 data bits plus 1 ctrl bit per lane).
- Checks frame payload length, inter-packet gap and control-code legality, with runtime-independent lane count, limits and statistics.
- Sits beside the TX path, never drives it, and feeds error pulses and saturating counters to the status/register block.

Parameters:
- LANES, 8: byte lanes per word; data width = 8*LANES.
- MIN_PAYLOAD, 46: minimum legal payload bytes.
- MAX_PAYLOAD, 150: maximum legal payload bytes.
- MIN_IPG, 12: minimum legal gap bytes.
- MAX_IPG, 40: maximum legal gap bytes.
- LEN_WIDTH, 16: width of the length and gap counters; both saturate at all-ones.
- CNT_WIDTH, 16: width of the statistics counters; they saturate.

Ports:
- clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  word qualifier; when low the word is ignored and no state or counter changes.
- i_tx_data  in  8*LANES  lane k = bits [8k+7:8k].
- i_tx_ctrl  in  LANES  ctrl bit per lane.
- i_clr_stats  in  1  synchronous clear of o_frame_cnt and o_err_cnt.
- o_frame_valid  out  1  one-cycle pulse: a frame closed with TERM.
- o_frame_len  out  LEN_WIDTH  payload bytes of that frame; holds its value between pulses.
- o_payload_err  out  1  pulse.
- o_ipg_err  out  1  pulse.
- o_ctrl_err  out  1  pulse.
- o_frame_cnt  out  CNT_WIDTH  count of good frames.
- o_err_cnt  out  CNT_WIDTH  count of cycles with any error pulse.

Behaviour:
- One clock. Reset is asynchronous and active-low. While i_rst_n=0: all outputs are 0 and state is WAIT_START. Reset mid-frame discards the frame with no pulses.
- Latency: every output is registered, one cycle after the sampled word.
- Lane scan, per word:
  - first lane t with ctrl=1 and code TERM (0xFD);
  - first lane s with ctrl=1 and code START (0xFB);
  - any other ctrl=1 byte that is not IDLE (0x07) flags an illegal control byte.
- States: WAIT_START, IN_FRAME, IN_GAP.
- WAIT_START:
  - START at lane s -> IN_FRAME, len = LANES-1-s.
  - No IPG check on the first frame after reset.
- IN_FRAME, no TERM in word:
  - every ctrl bit must be 0, and len += LANES (saturating).
  - Illegal control byte -> o_ctrl_err, frame aborted (no o_frame_valid), -> IN_GAP with gap = 0.
  - START inside frame -> o_ctrl_err, old frame dropped, new frame begins at s.
- IN_FRAME, TERM at lane t:
  - len += t; o_frame_len = len; o_frame_valid = 1.
  - o_payload_err = (len < MIN_PAYLOAD or len > MAX_PAYLOAD).
  - o_frame_cnt increments only if no error is flagged this cycle.
  - Lanes after t must be IDLE or a START at s > t; any other byte there -> o_ctrl_err (the frame is still reported).
  - Gap = LANES-1-t.
- IN_GAP:
  - Lanes must be IDLE, ctrl=1; any data byte or illegal control byte -> o_ctrl_err, gap counting continues.
  - No START: gap += LANES (saturating).
  - START at s: gap += s; o_ipg_err = (gap < MIN_IPG or gap > MAX_IPG); -> IN_FRAME with len = LANES-1-s.
- Same-word TERM at t, then START at s > t:
  - gap = s-t-1, checked in the same cycle.
  - o_frame_valid and o_ipg_err may both assert in that cycle.
  - State stays IN_FRAME with the new len.
- A second TERM or START in one word (beyond the one TERM-then-START pair) -> o_ctrl_err; the extra code is ignored.
- TERM seen in WAIT_START or IN_GAP -> o_ctrl_err, no state change.
- Statistics:
  - o_err_cnt increments by 1 in any cycle where any error pulse is set.
  - i_clr_stats has priority over an increment in the same cycle.
  - Both counters saturate at all-ones.

Decomposition:
- Package mii_pkg holds:
  - the IDLE, START and TERM code constants;
  - the state_t enum {WAIT_START, IN_FRAME, IN_GAP};
  - a scan-result struct (term_found, term_lane, start_found, start_lane, illegal, data_in_gap, multi_code).
- Sub-module mii_lane_scan: purely combinational. Takes one word and LANES and returns the scan struct; priority is lowest lane first. The FSM, counters and output registers stay in the top level.

Test Plan (LANES=8):
- Good frame: START lane0, 5 data words, TERM lane3, IDLE afterwards -> next cycle o_frame_valid=1, o_frame_len=50, no errors, o_frame_cnt=1.
- Runt: START lane0, then TERM lane2 in the next word -> o_frame_len=9, o_payload_err=1, o_frame_cnt=0, o_err_cnt=1.
- IPG boundary:
  - TERM lane3 (gap 4), one IDLE word (gap 12), START lane0 -> no o_ipg_err.
  - TERM lane7 followed by START lane0 in the next word -> gap 0, o_ipg_err=1.
- Same-word pair: TERM lane1, START lane5 after a legal-length frame -> o_frame_valid=1 and o_ipg_err=1 in the same cycle (gap 3); the next frame's len starts at 2.
- Illegal control byte: ctrl=1 with 0xFE in lane4 mid-frame -> o_ctrl_err=1, no o_frame_valid for that frame, the following frame checks normally.
- Async reset: assert i_rst_n=0 mid-frame, release, then send a word with TERM -> all outputs 0 during reset; after release o_ctrl_err=1 and o_frame_valid stays 0.
